alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Multi-cycle controller that owns the 8-bit combinational ALU and a small register file. It accepts ALU commands over a valid/ready handshake, stages operands into registered ALU inputs, writes the result back and keeps persistent carry and zero flags. A host-side write port preloads registers and a combinational read port inspects them. The ALU is instantiated beside this block and wired through the alu_* ports.

Parameters:
AW, 2, register address width; the register file has 2**AW entries of 8 bits.
FLAG_C_INIT, 0, reset value of the carry flag.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_op  in  4  ALU opcode, passed unchanged to alu_op
cmd_dst  in  AW  destination register
cmd_sa  in  AW  source register for ALU input a
cmd_sb  in  AW  source register for ALU input b
cmd_wen  in  1  1 = write result to cmd_dst; 0 = update flags only (compare/test)
wr_en  in  1  host register write
wr_addr  in  AW  host write address
wr_data  in  8  host write data
rd_addr  in  AW  host read address
rd_data  out  8  combinational read of regfile[rd_addr]
alu_a  out  8  registered ALU operand a
alu_b  out  8  registered ALU operand b
alu_carry  out  1  ALU carry-in, equal to flag_c
alu_op  out  4  registered ALU opcode
alu_c  in  8  ALU result
alu_carry_out  in  1  ALU carry/borrow out
alu_zero  in  1  ALU zero
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse on command completion
flag_c  out  1  carry flag
flag_z  out  1  zero flag

Behaviour:
- Reset (async, rst_n=0):
  - all registers = 0, flag_c = FLAG_C_INIT, flag_z = 0
  - alu_a/alu_b/alu_op = 0, done = 0, state = IDLE
- FSM states: IDLE -> READ -> EXEC -> IDLE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On a rising edge with cmd_valid & cmd_ready, latch op/dst/sa/sb/wen into an internal command register and go to READ.
- READ:
  - On the edge leaving READ, load alu_a=reg[sa], alu_b=reg[sb], alu_op=op from the pre-edge register contents, then go to EXEC.
  - sa==sb is legal; both operands get the same value.
- EXEC:
  - ALU outputs are combinational from the registered inputs and alu_carry=flag_c; they settle within this cycle.
  - On the edge leaving EXEC:
    - if wen, reg[dst] <= alu_c
    - flag_c <= alu_carry_out and flag_z <= alu_zero, for every opcode
    - done <= 1 for exactly one cycle; go to IDLE.
- Latency and throughput:
  - Accept edge T0, operand edge T1, writeback edge T2.
  - done is high during the cycle following T2; the result is visible on rd_data in that same cycle.
  - One command per 3 cycles at most. A new command can be accepted at the edge ending the done cycle, and done and cmd_ready are high together.
- alu_carry is a direct copy of flag_c. Carry-consuming ops therefore see the flag left by the previous command.
- Host writes:
  - Applied at any edge with wr_en, in any state.
  - If a host write and the EXEC writeback target the same register at the same edge, the writeback wins.
  - A host write at the T1 edge is not seen by the operand sample.
- rd_data is purely combinational. It reflects the register contents after the most recent edge.
- cmd_valid/cmd_* are ignored while busy. Fields need only be stable in the accept cycle.
- Reset asserted mid-command aborts it: no writeback, no done, flags reset.
- Unused op encodings are passed through as-is; no decoding occurs in this block.

Test Plan:
- Reset then host-load r0=0x7F, r1=0x81 -> rd_data shows the values the cycle after each write. flag_c=0, flag_z=0, cmd_ready=1.
- ADD op=0, dst=2, sa=0, sb=1, wen=1 -> done 3 cycles after accept. r2=0x00, flag_c=1, flag_z=1; cmd_ready low for 2 cycles.
- Following ADC op=1, dst=3, sa=0, sb=0 with flag_c=1 -> r3=0xFF, flag_c=0, flag_z=0.
- SUB op=2, dst=0, sa=0, sb=1 (0x7F-0x81) -> r0=0xFE, flag_c=1. Then CMP op=11, wen=0, sa=1, sb=1 -> no register changes, flag_z=1, flag_c=0.
- Collision: during EXEC of an op writing r2=0x00, drive wr_en to r2 with 0x55 on the same edge -> r2=0x00. A host write to r2 on the following edge gives r2=0x55.
- Hold cmd_valid high continuously with two commands -> the second is accepted only at the edge ending its predecessor's done cycle. Separately, assert rst_n=0 in EXEC -> destination unchanged from its pre-reset zero, no done pulse, state IDLE after release.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle controller for an external 8-bit ALU: stages operands from a small
// register file, writes results back and keeps persistent carry/zero flags.
module alu_sequencer #(
    parameter int   AW          = 2,
    parameter logic FLAG_C_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_sa,
    input  logic [AW-1:0] cmd_sb,
    input  logic          cmd_wen,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [7:0]    alu_a,
    output logic [7:0]    alu_b,
    output logic          alu_carry,
    output logic [3:0]    alu_op,
    input  logic [7:0]    alu_c,
    input  logic          alu_carry_out,
    input  logic          alu_zero,
    output logic          busy,
    output logic          done,
    output logic          flag_c,
    output logic          flag_z
);

    localparam int NREG = 2 ** AW;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    state_t          state_r;
    logic [7:0]      regs_r [NREG];
    logic [3:0]      op_r;
    logic [AW-1:0]   dst_r;
    logic [AW-1:0]   sa_r;
    logic [AW-1:0]   sb_r;
    logic            wen_r;
    logic            ready_r;
    logic            busy_r;
    logic            done_r;
    logic            flag_c_r;
    logic            flag_z_r;
    logic [7:0]      alu_a_r;
    logic [7:0]      alu_b_r;
    logic [3:0]      alu_op_r;

    // Command FSM, register file and flags; the EXEC writeback is assigned after
    // the host write so it wins a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'd0;
            end
            op_r     <= 4'd0;
            dst_r    <= '0;
            sa_r     <= '0;
            sb_r     <= '0;
            wen_r    <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            flag_c_r <= FLAG_C_INIT;
            flag_z_r <= 1'b0;
            alu_a_r  <= 8'd0;
            alu_b_r  <= 8'd0;
            alu_op_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            if (wr_en) begin
                regs_r[wr_addr] <= wr_data;
            end
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r    <= cmd_op;
                        dst_r   <= cmd_dst;
                        sa_r    <= cmd_sa;
                        sb_r    <= cmd_sb;
                        wen_r   <= cmd_wen;
                        state_r <= ST_READ;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                ST_READ: begin
                    alu_a_r  <= regs_r[sa_r];
                    alu_b_r  <= regs_r[sb_r];
                    alu_op_r <= op_r;
                    state_r  <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (wen_r) begin
                        regs_r[dst_r] <= alu_c;
                    end
                    flag_c_r <= alu_carry_out;
                    flag_z_r <= alu_zero;
                    done_r   <= 1'b1;
                    state_r  <= ST_IDLE;
                    ready_r  <= 1'b1;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign flag_c    = flag_c_r;
    assign flag_z    = flag_z_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;
    assign alu_carry = flag_c_r;
    assign rd_data   = regs_r[rd_addr];

endmodule
